// File: rtl/cp0_irq_timer_if.sv
// CP0 register access path shared with the status/cause block:
// MTC0 write strobe with regnum/sel addressing and a combinational read return.
interface cp0_irq_timer_if;
    logic [63:0] wr_data;
    logic [4:0]  regnum;
    logic [2:0]  sel;
    logic        MTC0;
    logic [63:0] rd_data;
    logic        rd_hit;

    modport master (
        output wr_data, regnum, sel, MTC0,
        input  rd_data, rd_hit
    );

    modport slave (
        input  wr_data, regnum, sel, MTC0,
        output rd_data, rd_hit
    );
endinterface

// File: rtl/cp0_irq_timer.sv
// Interrupt-source front end for CP0 Cause.IP[7:0]:
//   IP7     Count/Compare timer interrupt (TI)
//   IP6..2  external hw_irq lines, 2-flop synchronized
//   IP1..0  software interrupt bits
// Optional build macro CP0_IRQ_EDGE_LATCH_EN turns the hardware lines into
// rising-edge latched pending bits, cleared by write-1 to IRQ_ACK_REGISTER.
module cp0_irq_timer #(
    parameter int unsigned COUNT_DIV        = 2,
    parameter logic [4:0]  COUNT_REGISTER   = 5'd9,
    parameter logic [4:0]  COMPARE_REGISTER = 5'd11,
    parameter logic [4:0]  SWINT_REGISTER   = 5'd13,
    parameter logic [4:0]  IRQ_ACK_REGISTER = 5'd22
) (
    input  logic            clock,
    input  logic            reset,
    cp0_irq_timer_if.slave  bus,
    input  logic [4:0]      hw_irq,
    output logic [7:0]      interrupt_source
);
    localparam logic [7:0] PRESCALE_LAST = 8'(COUNT_DIV - 1);

    logic [7:0]  prescaler;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] count_next;
    logic        ti;
    logic [1:0]  sw;
    logic [4:0]  hw_meta;
    logic [4:0]  hw_sync;
    logic [4:0]  hw_view;
    logic        tick;
    logic        wr_sel0;
    logic        wr_count;
    logic        wr_compare;
    logic        wr_swint;
    logic        unused_bits;

    assign wr_sel0    = bus.MTC0 && (bus.sel == 3'd0);
    assign wr_count   = wr_sel0 && (bus.regnum == COUNT_REGISTER);
    assign wr_compare = wr_sel0 && (bus.regnum == COMPARE_REGISTER);
    assign wr_swint   = wr_sel0 && (bus.regnum == SWINT_REGISTER);
    assign tick       = (prescaler == PRESCALE_LAST);
    assign count_next = count + 32'd1;

    // Only the low word of the 64-bit write bus carries register data.
    assign unused_bits = ^{bus.wr_data[63:32], IRQ_ACK_REGISTER};

    // Prescaler and Count; a Count write restarts the prescaler and beats a tick.
    always_ff @(posedge clock) begin
        if (!reset) begin
            prescaler <= '0;
            count     <= '0;
        end else if (wr_count) begin
            prescaler <= '0;
            count     <= bus.wr_data[31:0];
        end else if (tick) begin
            prescaler <= '0;
            count     <= count_next;
        end else begin
            prescaler <= prescaler + 8'd1;
        end
    end

    // Compare and sticky TI; only a ticking increment onto Compare sets TI.
    always_ff @(posedge clock) begin
        if (!reset) begin
            compare <= '1;
            ti      <= 1'b0;
        end else if (wr_compare) begin
            compare <= bus.wr_data[31:0];
            ti      <= 1'b0;
        end else if (tick && !wr_count && (count_next == compare)) begin
            ti      <= 1'b1;
        end
    end

    // Software interrupt bits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sw <= '0;
        end else if (wr_swint) begin
            sw <= bus.wr_data[9:8];
        end
    end

    // Two-flop synchronizer for the asynchronous hardware lines.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hw_meta <= '0;
            hw_sync <= '0;
        end else begin
            hw_meta <= hw_irq;
            hw_sync <= hw_meta;
        end
    end

`ifdef CP0_IRQ_EDGE_LATCH_EN
    logic [4:0] hw_pending;
    logic [4:0] ack_mask;

    assign ack_mask = (wr_sel0 && (bus.regnum == IRQ_ACK_REGISTER)) ? bus.wr_data[6:2] : 5'b0;

    // Pending bits set on the edge the synchronized level rises; a fresh edge outranks an ack.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hw_pending <= '0;
        end else begin
            hw_pending <= (hw_pending & ~ack_mask) | (hw_meta & ~hw_sync);
        end
    end

    assign hw_view = hw_pending;
`else
    assign hw_view = hw_sync;
`endif

    // Every field is a flop output, so no input reaches Cause.IP combinationally.
    assign interrupt_source = {ti, hw_view, sw};

    // Combinational register read; Count shows its pre-write value during a write.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_hit  = 1'b0;
        if (bus.sel == 3'd0) begin
            if (bus.regnum == COUNT_REGISTER) begin
                bus.rd_hit  = 1'b1;
                bus.rd_data = {32'h0, count};
            end else if (bus.regnum == COMPARE_REGISTER) begin
                bus.rd_hit  = 1'b1;
                bus.rd_data = {32'h0, compare};
            end else if (bus.regnum == SWINT_REGISTER) begin
                bus.rd_hit  = 1'b1;
                bus.rd_data = {54'h0, sw, 8'h00};
`ifdef CP0_IRQ_EDGE_LATCH_EN
            end else if (bus.regnum == IRQ_ACK_REGISTER) begin
                bus.rd_hit  = 1'b1;
                bus.rd_data = {57'h0, hw_pending, 2'b00};
`endif
            end
        end
    end
endmodule

// File: doc/cp0_irq_timer.md
Name: cp0_irq_timer

Overview:
- Interrupt-source front end that sits directly upstream of the CP0 status/cause block and drives its 8-bit interrupt_source input (Cause.IP[7:0]).
- Provides the MIPS Count/Compare timer on IP7.
- Synchronizes five external hardware interrupt lines onto IP6..IP2.
- Holds two software-interrupt bits on IP1..IP0.
- Count, Compare and the software bits are accessed through the same MTC0 write / regnum+sel read path the CP0 block uses; the CP0 read mux selects this block's rd_data when rd_hit=1.

Parameters:
- COUNT_DIV, 2, core clocks per Count increment (1..255).
- COUNT_REGISTER, 5'd9, CP0 register number of Count.
- COMPARE_REGISTER, 5'd11, CP0 register number of Compare.
- SWINT_REGISTER, 5'd13, CP0 register number used for software-interrupt bits (Cause, sel 0, bits 9:8).
- IRQ_ACK_REGISTER, 5'd22, write-1-to-clear register for latched hardware IRQs (sel 0, bits 6:2); used only with the optional feature.

Ports:
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset, sampled on the rising edge of clock)
- wr_data  in  64  MTC0 write data; only bits 31:0 used
- regnum  in  5  CP0 register number
- sel  in  3  CP0 select
- MTC0  in  1  write strobe for the addressed register
- hw_irq  in  5  asynchronous external interrupt lines, active-high
- rd_data  out  64  zero-extended read of Count, Compare or SWINT bits
- rd_hit  out  1  regnum/sel addresses a register owned by this block
- interrupt_source  out  8  {TI, hw[4:0], sw[1:0]} to CP0 Cause.IP

Behaviour:
- Reset (reset==0 at a clock edge): Count=0, Compare=32'hFFFF_FFFF, prescaler=0, TI=0, sw=0, synchronizer flops=0, latched hw=0. Result: interrupt_source=8'h00. rd_data follows the combinational read of the reset values.
- A write is MTC0 & sel==0 & regnum==X.
- Prescaler:
  - Counts 0..COUNT_DIV-1 and wraps.
  - tick=1 in the cycle the prescaler equals COUNT_DIV-1.
  - With COUNT_DIV=1, tick=1 every cycle.
- Count:
  - On tick, Count <= Count+1, mod 2^32; 32'hFFFF_FFFF wraps to 0 with no flag.
  - A Count write loads wr_data[31:0] and clears the prescaler.
  - A Count write wins over a simultaneous tick.
- Timer interrupt:
  - TI sets at the edge where tick=1 and Count+1 == Compare, i.e. on the same edge Count becomes equal to Compare.
  - Loading Count with a value equal to Compare does not set TI.
  - TI is sticky until a Compare write.
  - A Compare write loads wr_data[31:0] and clears TI. If a set and a Compare write coincide, the clear wins.
- Software bits:
  - A SWINT_REGISTER write loads sw <= wr_data[9:8].
  - On read, the bits are returned at positions 9:8, all other bits 0.
- Hardware lines:
  - Each hw_irq bit passes through a 2-flop synchronizer.
  - interrupt_source[6:2] = synchronized level, so latency from hw_irq to output is 2 edges.
- interrupt_source is registered-only: no combinational path from any input.
- Reads are combinational:
  - rd_hit=1 for sel==0 and regnum in {COUNT, COMPARE, SWINT}; otherwise rd_hit=0 and rd_data=0.
  - A read of Count during a write cycle returns the pre-write value.
- All state updates are gated by reset==1; reset asserted mid-count discards any in-flight write or tick.

Optional Feature:
- Macro: CP0_IRQ_EDGE_LATCH_EN.
- Defined:
  - A rising edge on a synchronized hw bit (previous 0, current 1) sets a sticky pending bit, and interrupt_source[6:2] shows the pending bits.
  - An IRQ_ACK_REGISTER write clears each pending bit whose wr_data[6:2] bit is 1.
  - A new edge in the same cycle as its clear leaves the bit set.
  - IRQ_ACK_REGISTER reads return the pending bits at 6:2 with rd_hit=1.
- Undefined: level passthrough as above; IRQ_ACK_REGISTER is not decoded (rd_hit=0, writes ignored).

Test Plan:
- COUNT_DIV=2; release reset, write Compare=5 at cycle 1 -> Count reaches 5 on the 10th edge after the prescaler restarts, interrupt_source=8'h80 on that edge, TI holds until a Compare write.
- TI=1, then write Compare=100 -> interrupt_source[7]=0 the next cycle. Force a tick setting TI in the same cycle as the Compare write -> TI stays 0.
- Write Count=32'hFFFF_FFFE, Compare=0, COUNT_DIV=1 -> Count goes FFFF_FFFF then 0, and TI sets on the wrap edge.
- Write SWINT with wr_data=32'h0000_0300 -> interrupt_source[1:0]=2'b11; read regnum 13 -> rd_data=64'h300, rd_hit=1. Read regnum 12 -> rd_hit=0, rd_data=0.
- Pulse hw_irq[2] high for 3 cycles:
  - Macro undefined: interrupt_source[4] high for 3 cycles, starting 2 edges later.
  - Macro defined: the bit stays high until an ack write with wr_data=32'h10.
- Assert reset=0 for one edge mid-count (Count=37, TI=1, sw=2'b01) -> Count=0, Compare=FFFF_FFFF, interrupt_source=8'h00 after that edge.
